sobel_edge_pipe: RTL and testbench
==================================

Name: sobel_edge_pipe

Overview:
Parametrised, pipelined Sobel edge detector for the video path. It accepts one pre-assembled KSIZE×KSIZE pixel window per transfer, with KSIZE of 3 or 5, and computes Gx, Gy and |Gx|+|Gy|. It applies a runtime-programmable threshold and emits a binary edge pixel plus a saturated magnitude pixel. A valid/ready handshake with full backpressure connects it between the window line-buffer and the display/frame-store writer, and a per-frame edge-pixel counter supports threshold calibration.

Parameters:
PIX_W, 8, bits per input pixel (unsigned).
KSIZE, 5, kernel size; legal values 3 or 5. Any other value is an elaboration error.
ACC_W, 16, signed width of Gx/Gy; must cover ±(255·48) for KSIZE=5.
MAG_SHIFT, 6, right shift applied to the sum before 8-bit saturation on mag_out.
EDGE_VAL, 8'h00, edge_out value on an edge; the non-edge value is ~EDGE_VAL.
CNT_W, 20, width of the edge counter.

Ports:
clock  in  1  system clock, all logic on posedge.
reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  window valid.
in_ready  out  1  block can accept a window this cycle.
window  in  KSIZE*KSIZE*PIX_W  row-major window; element k (row r, col c, k=r*KSIZE+c) at bits [W-1-k*PIX_W -: PIX_W], with k=0 top-left.
sof  in  1  start-of-frame marker, qualified by the in_valid&in_ready transfer.
threshold  in  ACC_W  edge threshold, sampled with each accepted window.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
edge_out  out  8  EDGE_VAL if sum > threshold, else ~EDGE_VAL.
mag_out  out  8  min(sum>>MAG_SHIFT, 255).
sum_out  out  ACC_W  unsigned |Gx|+|Gy|, saturated to all-ones.
edge_count  out  CNT_W  edges in the previous completed frame.
count_valid  out  1  one-cycle pulse when edge_count updates.

Behaviour:
- Kernels:
  - Gx = right minus left; Gy = top minus bottom.
  - KSIZE=3: Gx rows weighted 1,2,1 with columns -1,0,+1; Gy is the transpose.
  - KSIZE=5: Gx column weights (-1,-2,0,+2,+1) per row, rows scaled 1,4,6,4,1. Effective magnitudes: row0/4 = 1,2; row1/3 = 4,8; row2 = 6,12. Gy is the exact transpose.
- Arithmetic: pixels are zero-extended before subtraction; all sums are signed ACC_W; no wrap is allowed at the parameter defaults. Absolute value uses two's complement; sum saturates at 2^ACC_W-1.
- Pipeline, 4 stages, latency 4 cycles from accepted input to out_valid when not stalled:
  - S1: row partial products.
  - S2: Gx, Gy.
  - S3: |Gx|, |Gy|.
  - S4: sum, compare, mag, edge.
- Each stage has a valid bit. A stage advances when its successor is empty or advancing.
- in_ready = !S1_valid | S1_advance. The block accepts full throughput: one window per cycle while out_ready=1.
- Outputs hold stable while out_valid=1 and out_ready=0. No data is dropped or duplicated.
- threshold and sof travel down the pipeline with their window. A threshold change affects only windows accepted afterwards.
- Edge counter:
  - Increments when an S4 result with edge=1 is consumed (out_valid&out_ready).
  - When a result carrying sof is consumed, the running count is copied to edge_count and count_valid pulses. The running count then restarts at edge(this pixel).
  - The first sof after reset publishes 0.
  - On wrap at 2^CNT_W-1 the counter saturates.
- Reset (asynchronous assert, synchronous-safe deassert assumed upstream):
  - All valid bits 0, out_valid=0, in_ready=1 after reset.
  - edge_out=~EDGE_VAL, mag_out=0, sum_out=0, edge_count=0, count_valid=0.
  - Reset mid-stream discards all in-flight windows.
- Simultaneous sof with an edge pixel: the published count excludes that pixel; the new count starts at 1.

Test Plan:
- KSIZE=3, flat window (all 100), threshold 1000 → after 4 cycles sum_out=0, edge_out=8'hFF, mag_out=0.
- KSIZE=3, col0=0 and cols1-2=255 → Gx=+1020, Gy=0, sum_out=1020. Threshold 1000 → edge_out=8'h00, mag_out=15. Threshold 1020 → edge_out=8'hFF.
- KSIZE=5, cols 3-4=255 and cols 0-2=0 → sum_out=12240, mag_out=191. Transposed (rows 0-1=255) → Gy=+12240, same sum. Negated step (cols 0-1=255) → sum 12240, verifying abs.
- Stream 20 windows with out_ready toggling on a 3-on/2-off pattern → all 20 results emerge in order with no loss or duplicates, and outputs stay stable during stalls.
- Frame of 8 windows (4 edges) with sof on the 1st window, then sof again → count_valid pulses with edge_count=0, then with edge_count=4.
- Assert reset_n=0 with 3 windows in flight → out_valid=0 immediately and edge_count=0. After release, only new windows appear.

Source files
------------

// File: rtl/sobel_edge_pipe.sv
// rtl/sobel_edge_pipe.sv - four-stage KSIZE x KSIZE Sobel edge detector with per-frame edge counter
// Takes one full window per transfer; valid/ready with full backpressure on both sides.
module sobel_edge_pipe #(
  parameter int         PIX_W     = 8,
  parameter int         KSIZE     = 5,
  parameter int         ACC_W     = 16,
  parameter int         MAG_SHIFT = 6,
  parameter logic [7:0] EDGE_VAL  = 8'h00,
  parameter int         CNT_W     = 20
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [KSIZE*KSIZE*PIX_W-1:0] window,
  input  logic                         sof,
  input  logic [ACC_W-1:0]             threshold,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   edge_out,
  output logic [7:0]                   mag_out,
  output logic [ACC_W-1:0]             sum_out,
  output logic [CNT_W-1:0]             edge_count,
  output logic                         count_valid
);
  localparam int W = KSIZE * KSIZE * PIX_W;
  typedef logic signed [ACC_W-1:0] acc_t;

  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("sobel_edge_pipe: KSIZE must be 3 or 5");
  end

  // Derivative taps run along the gradient axis, smoothing taps across it.
  function automatic int deriv_w(input int i);
    if (KSIZE == 3) return i - 1;
    case (i)
      0:       return -1;
      1:       return -2;
      3:       return 2;
      4:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int smooth_w(input int i);
    if (KSIZE == 3) return (i == 1) ? 2 : 1;
    case (i)
      1, 3:    return 4;
      2:       return 6;
      default: return 1;
    endcase
  endfunction

  logic             v1, v2, v3;
  logic             ld1, ld2, ld3, ld4;
  acc_t             rx_c [KSIZE];
  acc_t             cy_c [KSIZE];
  acc_t             rx1  [KSIZE];
  acc_t             cy1  [KSIZE];
  acc_t             gx_c, gy_c, gx2, gy2;
  logic [ACC_W-1:0] ax_c, ay_c, ax3, ay3;
  logic [ACC_W-1:0] thr1, thr2, thr3;
  logic             sof1, sof2, sof3, sof4;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_c, shifted;
  logic             edge_c, e4;
  logic [7:0]       mag_c;
  logic [CNT_W-1:0] run_cnt;

  assign ld4      = !out_valid || out_ready;
  assign ld3      = !v3 || ld4;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;

  // S1: Gx partials per row, Gy partials per column (Gy = top minus bottom).
  always_comb begin
    for (int i = 0; i < KSIZE; i++) begin
      rx_c[i] = '0;
      cy_c[i] = '0;
    end
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        rx_c[r] = rx_c[r] + acc_t'(deriv_w(c)) * acc_t'(window[W-1-(r*KSIZE+c)*PIX_W -: PIX_W]);
        cy_c[c] = cy_c[c] - acc_t'(deriv_w(r)) * acc_t'(window[W-1-(r*KSIZE+c)*PIX_W -: PIX_W]);
      end
    end
  end

  always_comb begin
    gx_c = '0;
    gy_c = '0;
    for (int i = 0; i < KSIZE; i++) begin
      gx_c = gx_c + acc_t'(smooth_w(i)) * rx1[i];
      gy_c = gy_c + acc_t'(smooth_w(i)) * cy1[i];
    end
  end

  assign ax_c = gx2[ACC_W-1] ? -gx2 : gx2;
  assign ay_c = gy2[ACC_W-1] ? -gy2 : gy2;

  assign sum_wide = {1'b0, ax3} + {1'b0, ay3};
  assign sum_c    = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
  assign edge_c   = sum_c > thr3;
  assign shifted  = sum_c >> MAG_SHIFT;
  assign mag_c    = (|shifted[ACC_W-1:8]) ? 8'hFF : shifted[7:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      out_valid   <= 1'b0;
      rx1         <= '{default: '0};
      cy1         <= '{default: '0};
      gx2         <= '0;
      gy2         <= '0;
      ax3         <= '0;
      ay3         <= '0;
      thr1        <= '0;
      thr2        <= '0;
      thr3        <= '0;
      sof1        <= 1'b0;
      sof2        <= 1'b0;
      sof3        <= 1'b0;
      sof4        <= 1'b0;
      e4          <= 1'b0;
      edge_out    <= ~EDGE_VAL;
      mag_out     <= '0;
      sum_out     <= '0;
      run_cnt     <= '0;
      edge_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
      if (ld4) out_valid <= v3;
      if (ld1 && in_valid) begin
        rx1  <= rx_c;
        cy1  <= cy_c;
        thr1 <= threshold;
        sof1 <= sof;
      end
      if (ld2 && v1) begin
        gx2  <= gx_c;
        gy2  <= gy_c;
        thr2 <= thr1;
        sof2 <= sof1;
      end
      if (ld3 && v2) begin
        ax3  <= ax_c;
        ay3  <= ay_c;
        thr3 <= thr2;
        sof3 <= sof2;
      end
      if (ld4 && v3) begin
        sum_out  <= sum_c;
        mag_out  <= mag_c;
        edge_out <= edge_c ? EDGE_VAL : ~EDGE_VAL;
        e4       <= edge_c;
        sof4     <= sof3;
      end
      // A sof result publishes the count of the frame it closes, then seeds the next.
      if (out_valid && out_ready) begin
        if (sof4) begin
          edge_count  <= run_cnt;
          count_valid <= 1'b1;
          run_cnt     <= CNT_W'(e4);
        end else if (e4 && run_cnt != '1) begin
          run_cnt <= run_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// tb/tb_sobel_edge_pipe.sv - directed vector bench for sobel_edge_pipe at KSIZE=3 and KSIZE=5
module tb_sobel_edge_pipe;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid [2];
  logic         in_ready [2];
  logic         sof [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic         count_valid [2];
  logic [199:0] win [2];
  logic [15:0]  thr [2];
  logic [15:0]  sum_o [2];
  logic [7:0]   edge_o [2];
  logic [7:0]   mag_o [2];
  logic [19:0]  cnt_o [2];

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  sobel_edge_pipe #(.KSIZE(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .window(win[0][71:0]), .sof(sof[0]), .threshold(thr[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .edge_out(edge_o[0]), .mag_out(mag_o[0]), .sum_out(sum_o[0]),
    .edge_count(cnt_o[0]), .count_valid(count_valid[0])
  );

  sobel_edge_pipe #(.KSIZE(5)) u_dut5 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .window(win[1]), .sof(sof[1]), .threshold(thr[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .edge_out(edge_o[1]), .mag_out(mag_o[1]), .sum_out(sum_o[1]),
    .edge_count(cnt_o[1]), .count_valid(count_valid[1])
  );

  typedef struct {
    int d;
    int colm;
    int rowm;
    int hi;
    int lo;
    int th;
    int esum;
    int eedge;
    int emag;
  } vec_t;

  vec_t         vecs [11];
  logic [199:0] q_win [$];
  logic         q_sof [$];
  logic [15:0]  q_thr [$];
  int           q_esum [$];
  int           q_eedge [$];
  int           cnt_seen [$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [199:0] mk_win(input int ks, input int colm, input int rowm,
                                          input int hi, input int lo);
    logic [199:0] w = '0;
    for (int r = 0; r < ks; r++) begin
      for (int c = 0; c < ks; c++) begin
        int k = r * ks + c;
        w[ks*ks*8-1-k*8 -: 8] = ((((colm >> c) & 1) != 0) || (((rowm >> r) & 1) != 0)) ? 8'(hi) : 8'(lo);
      end
    end
    return w;
  endfunction

  task automatic apply_one(input vec_t v, input int idx);
    int lat;
    @(negedge clock);
    win[v.d]       = mk_win(v.d ? 5 : 3, v.colm, v.rowm, v.hi, v.lo);
    thr[v.d]       = 16'(v.th);
    sof[v.d]       = 1'b0;
    out_ready[v.d] = 1'b1;
    in_valid[v.d]  = 1'b1;
    @(posedge clock);
    #1;
    in_valid[v.d] = 1'b0;
    thr[v.d]      = ~16'(v.th);
    lat = 1;
    while (!out_valid[v.d] && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check($sformatf("vec%0d_latency", idx), lat, 4);
    check($sformatf("vec%0d_sum", idx), sum_o[v.d], v.esum);
    check($sformatf("vec%0d_edge", idx), edge_o[v.d], v.eedge);
    check($sformatf("vec%0d_mag", idx), mag_o[v.d], v.emag);
    @(negedge clock);
  endtask

  task automatic run_stream(input int d, input bit toggle);
    int   sent = 0;
    int   got = 0;
    int   cyc = 0;
    int   n;
    bit   held = 1'b0;
    logic [32:0] snap;
    n = q_win.size();
    cnt_seen.delete();
    while (got < n && cyc < 400) begin
      @(negedge clock);
      out_ready[d] = toggle ? ((cyc % 5) < 3) : 1'b1;
      in_valid[d]  = (sent < n);
      if (sent < n) begin
        win[d] = q_win[sent];
        sof[d] = q_sof[sent];
        thr[d] = q_thr[sent];
      end
      #1;
      if (held) check($sformatf("stall_hold_cyc%0d", cyc), {out_valid[d], sum_o[d], edge_o[d], mag_o[d]}, snap);
      if (count_valid[d]) cnt_seen.push_back(int'(cnt_o[d]));
      held = out_valid[d] && !out_ready[d];
      snap = {out_valid[d], sum_o[d], edge_o[d], mag_o[d]};
      if (out_valid[d] && out_ready[d]) begin
        check($sformatf("stream_sum%0d", got), sum_o[d], q_esum[got]);
        check($sformatf("stream_edge%0d", got), edge_o[d], q_eedge[got]);
        got++;
      end
      if (in_valid[d] && in_ready[d]) sent++;
      cyc++;
    end
    @(negedge clock);
    in_valid[d] = 1'b0;
    sof[d]      = 1'b0;
    #1;
    if (count_valid[d]) cnt_seen.push_back(int'(cnt_o[d]));
    check("stream_result_count", got, n);
    check("stream_no_extra", out_valid[d], 0);
  endtask

  initial begin
    int edge_px;
    int ghosts;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      sof[d]       = 1'b0;
      out_ready[d] = 1'b1;
      win[d]       = '0;
      thr[d]       = '0;
    end

    vecs[0]  = '{0, 0, 0, 100, 100, 1000, 0, 8'hFF, 0};
    vecs[1]  = '{0, 6, 0, 255, 0, 1000, 1020, 8'h00, 15};
    vecs[2]  = '{0, 6, 0, 255, 0, 1020, 1020, 8'hFF, 15};
    vecs[3]  = '{0, 3, 0, 255, 0, 1019, 1020, 8'h00, 15};
    vecs[4]  = '{1, 24, 0, 255, 0, 1000, 12240, 8'h00, 191};
    vecs[5]  = '{1, 0, 3, 255, 0, 1000, 12240, 8'h00, 191};
    vecs[6]  = '{1, 3, 0, 255, 0, 1000, 12240, 8'h00, 191};
    vecs[7]  = '{1, 0, 24, 255, 0, 12240, 12240, 8'hFF, 191};
    vecs[8]  = '{1, 1, 0, 255, 0, 4079, 4080, 8'h00, 63};
    vecs[9]  = '{1, 4, 0, 255, 0, 0, 0, 8'hFF, 0};
    vecs[10] = '{1, 2, 0, 255, 0, 8159, 8160, 8'h00, 127};

    repeat (2) @(negedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_out_valid", d), out_valid[d], 0);
      check($sformatf("rst%0d_in_ready", d), in_ready[d], 1);
      check($sformatf("rst%0d_edge", d), edge_o[d], 8'hFF);
      check($sformatf("rst%0d_mag", d), mag_o[d], 0);
      check($sformatf("rst%0d_sum", d), sum_o[d], 0);
      check($sformatf("rst%0d_count", d), cnt_o[d], 0);
      check($sformatf("rst%0d_count_valid", d), count_valid[d], 0);
    end
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) apply_one(vecs[i], i);

    // Twenty windows with col2 = 10*i+5 give sum 4*(10*i+5); ready runs 3 on, 2 off.
    q_win.delete(); q_sof.delete(); q_thr.delete(); q_esum.delete(); q_eedge.delete();
    for (int i = 0; i < 20; i++) begin
      q_win.push_back(mk_win(3, 4, 0, i * 10 + 5, 0));
      q_sof.push_back(1'b0);
      q_thr.push_back(16'd500);
      q_esum.push_back(4 * (i * 10 + 5));
      q_eedge.push_back((4 * (i * 10 + 5) > 500) ? 8'h00 : 8'hFF);
    end
    run_stream(0, 1'b1);

    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Frame: edges at 1,2,5,7; window 8 is sof+edge, window 9 is sof+non-edge.
    q_win.delete(); q_sof.delete(); q_thr.delete(); q_esum.delete(); q_eedge.delete();
    for (int i = 0; i < 10; i++) begin
      edge_px = (i == 1 || i == 2 || i == 5 || i == 7 || i == 8);
      q_win.push_back(edge_px ? mk_win(3, 6, 0, 255, 0) : mk_win(3, 0, 0, 100, 100));
      q_sof.push_back(i == 0 || i == 8 || i == 9);
      q_thr.push_back(16'd1000);
      q_esum.push_back(edge_px ? 1020 : 0);
      q_eedge.push_back(edge_px ? 8'h00 : 8'hFF);
    end
    run_stream(0, 1'b0);
    check("frame_pulses", cnt_seen.size(), 3);
    check("frame_pub0", (cnt_seen.size() > 0) ? cnt_seen[0] : -1, 0);
    check("frame_pub1", (cnt_seen.size() > 1) ? cnt_seen[1] : -1, 4);
    check("frame_pub2", (cnt_seen.size() > 2) ? cnt_seen[2] : -1, 1);

    // Reset with four windows in flight and the head result stalled.
    @(negedge clock);
    out_ready[1] = 1'b0;
    win[1]       = mk_win(5, 24, 0, 255, 0);
    thr[1]       = 16'd1000;
    in_valid[1]  = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    in_valid[1] = 1'b0;
    check("inflight_out_valid", out_valid[1], 1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid[1], 0);
    check("midrst_in_ready", in_ready[1], 1);
    check("midrst_sum", sum_o[1], 0);
    check("midrst_edge", edge_o[1], 8'hFF);
    check("midrst_count3", cnt_o[0], 0);
    @(negedge clock);
    reset_n      = 1'b1;
    out_ready[1] = 1'b1;
    ghosts = 0;
    repeat (8) begin
      @(negedge clock);
      #1;
      if (out_valid[1]) ghosts++;
    end
    check("midrst_ghosts", ghosts, 0);
    apply_one(vecs[8], 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
